hue_stage1: RTL and testbench

- Pipelined hue-angle computation stage in the color-detect path.
- Takes a signed channel difference (dividend), a chroma range (divisor) and a sector select; produces hue in integer degrees.
- Formula: 60*dividend/divisor plus a 0/120/240 sector offset, wrapped into [0,360).
- Fully pipelined: accepts one sample per clock, fixed latency, no backpressure.

---
 rtl/hue_stage1.sv | 154 +++++++++++++++
 tb/tb_hue_stage1.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hue_stage1.sv
// hue_stage1: pipelined hue-angle stage for the color-detect path.
// Computes 60*dividend/divisor plus a sector offset (0/120/240), wrapped
// once into [0,360). One sample per clock, fixed latency, no backpressure.
//
// Handshake: i_valid marks a sample that is captured on the rising edge of
// i_clk; there is no ready, the stage always accepts. o_valid is high for
// exactly one cycle per accepted sample, DIVIDE_LATENCY+2 register stages
// later, in input order; gaps in i_valid reappear as gaps in o_valid.
// o_data changes only alongside o_valid and holds its value otherwise.
module hue_stage1 #(
    // Divider pipeline depth; at least 14 (one quotient bit per stage),
    // extra stages only add delay.
    parameter int DIVIDE_LATENCY = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic signed [8:0] i_dividend,
    input  logic        [8:0] i_divisor,
    input  logic        [1:0] i_function,
    input  logic              i_valid,
    output logic       [15:0] o_data,
    output logic              o_valid
);

    localparam int L         = DIVIDE_LATENCY;
    localparam int DIV_STEPS = 14;

    // Index 0 is the input stage, index i (1..L) is divider stage i.
    logic [13:0] dq_q    [0:L];  // dividend bits shift out MSB, quotient bits shift in LSB
    logic [8:0]  rem_q   [0:L];  // partial remainder, always < divisor
    logic [8:0]  dvs_q   [0:L];
    logic        sign_q  [0:L];
    logic        zero_q  [0:L];
    logic [1:0]  func_q  [0:L];
    logic        valid_q [0:L];

    logic [8:0]  abs_dividend;
    logic [13:0] mag60;
    logic signed [15:0] mag_s;
    logic signed [15:0] q_s;
    logic signed [15:0] offset_s;
    logic signed [15:0] h_s;
    logic [15:0] hue;

    // One restoring-division step: bring down the next dividend bit and
    // subtract the divisor if it fits. A true difference is below 512, so
    // the 9-bit subtraction is exact whenever it is kept.
    function automatic logic [22:0] div_step(input logic [8:0]  rem,
                                             input logic [13:0] dq,
                                             input logic [8:0]  dvs);
        logic [9:0] trial;
        logic [8:0] diff;
        trial = {rem, dq[13]};
        diff  = trial[8:0] - dvs;
        if (trial >= {1'b0, dvs}) begin
            return {diff, dq[12:0], 1'b1};
        end
        return {trial[8:0], dq[12:0], 1'b0};
    endfunction

    // Magnitude of the dividend scaled by 60; -256 maps to 256 -> 15360.
    always_comb begin
        abs_dividend = i_dividend[8] ? (~i_dividend + 9'd1) : i_dividend;
        mag60        = {5'b0, abs_dividend} * 14'd60;
    end

    // Input stage: capture payload only for valid samples.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q[0] <= 1'b0;
            sign_q[0]  <= 1'b0;
            dq_q[0]    <= '0;
            rem_q[0]   <= '0;
            dvs_q[0]   <= '0;
            zero_q[0]  <= 1'b0;
            func_q[0]  <= '0;
        end else begin
            valid_q[0] <= i_valid;
            rem_q[0]   <= '0;
            if (i_valid) begin
                sign_q[0] <= i_dividend[8];
                dq_q[0]   <= mag60;
                dvs_q[0]  <= i_divisor;
                zero_q[0] <= (i_divisor == 9'd0);
                func_q[0] <= i_function;
            end
        end
    end

    // Divider pipeline: first 14 stages each resolve one quotient bit,
    // later stages just delay; side-band fields move in lockstep.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 1; i <= L; i++) begin
                valid_q[i] <= 1'b0;
                sign_q[i]  <= 1'b0;
                dq_q[i]    <= '0;
                rem_q[i]   <= '0;
                dvs_q[i]   <= '0;
                zero_q[i]  <= 1'b0;
                func_q[i]  <= '0;
            end
        end else begin
            for (int i = 1; i <= L; i++) begin
                valid_q[i] <= valid_q[i-1];
                sign_q[i]  <= sign_q[i-1];
                dvs_q[i]   <= dvs_q[i-1];
                zero_q[i]  <= zero_q[i-1];
                func_q[i]  <= func_q[i-1];
                if (i <= DIV_STEPS) begin
                    {rem_q[i], dq_q[i]} <= div_step(rem_q[i-1], dq_q[i-1], dvs_q[i-1]);
                end else begin
                    rem_q[i] <= rem_q[i-1];
                    dq_q[i]  <= dq_q[i-1];
                end
            end
        end
    end

    // Apply sign, add the sector offset, wrap negatives once by +360, and
    // force zero for achromatic samples or no sector.
    always_comb begin
        mag_s    = $signed({2'b00, dq_q[L]});
        q_s      = sign_q[L] ? -mag_s : mag_s;
        offset_s = 16'sd0;
        case (func_q[L])
            2'd2:    offset_s = 16'sd120;
            2'd3:    offset_s = 16'sd240;
            default: offset_s = 16'sd0;
        endcase
        h_s = q_s + offset_s;
        if (h_s < 16'sd0) begin
            h_s = h_s + 16'sd360;
        end
        hue = $unsigned(h_s);
        if (zero_q[L] || (func_q[L] == 2'd0)) begin
            hue = '0;
        end
    end

    // Output stage: o_data only moves with a valid result.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= valid_q[L];
            if (valid_q[L]) begin
                o_data <= hue;
            end
        end
    end

endmodule

// File: tb/tb_hue_stage1.sv
// tb_hue_stage1: randomized and directed bench for hue_stage1 at divider
// depths 16, 14 and 20, all driven by the same input stream.
module tb_hue_stage1;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic              i_rstn;
  logic signed [8:0] i_dividend;
  logic        [8:0] i_divisor;
  logic        [1:0] i_function;
  logic              i_valid;

  logic [15:0] o_data  [3];
  logic        o_valid [3];

  hue_stage1 #(.DIVIDE_LATENCY(16)) u_dut16 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_dividend(i_dividend), .i_divisor(i_divisor),
    .i_function(i_function), .i_valid(i_valid), .o_data(o_data[0]), .o_valid(o_valid[0])
  );
  hue_stage1 #(.DIVIDE_LATENCY(14)) u_dut14 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_dividend(i_dividend), .i_divisor(i_divisor),
    .i_function(i_function), .i_valid(i_valid), .o_data(o_data[1]), .o_valid(o_valid[1])
  );
  hue_stage1 #(.DIVIDE_LATENCY(20)) u_dut20 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_dividend(i_dividend), .i_divisor(i_divisor),
    .i_function(i_function), .i_valid(i_valid), .o_data(o_data[2]), .o_valid(o_valid[2])
  );

  function automatic int lat_of(input int k);
    case (k)
      0:       return 16;
      1:       return 14;
      default: return 20;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Hue straight from the arithmetic definition: truncating division,
  // sector offset (fn-1)*120, a single +360 wrap, 16-bit result.
  function automatic logic [15:0] hue_model(input int dvd, input int dvs, input int fn);
    int mag;
    int h;
    if (dvs == 0 || fn == 0) return 16'd0;
    mag = ((dvd < 0) ? -dvd : dvd) * 60 / dvs;
    h = ((dvd < 0) ? -mag : mag) + (fn - 1) * 120;
    if (h < 0) h = h + 360;
    return 16'(h);
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  logic [15:0] exp_q[$];
  int          exp_edge[$];
  int          rd   [3];
  logic [15:0] held [3];

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  // Record every accepted sample with its capture-edge index.
  always @(posedge i_clk) begin
    if (i_rstn && i_valid) begin
      exp_q.push_back(hue_model(int'(i_dividend), int'(i_divisor), int'(i_function)));
      exp_edge.push_back(edge_cnt);
    end
    edge_cnt <= edge_cnt + 1;
  end

  // Compare each instance's outputs away from the active edge.
  always @(negedge i_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!i_rstn) begin
        check("rst_valid", 16'(o_valid[k]), 16'd0);
        check("rst_data", o_data[k], 16'd0);
        rd[k]   = exp_q.size();
        held[k] = 16'd0;
      end else if (o_valid[k]) begin
        if (rd[k] < exp_q.size()) begin
          check($sformatf("data_L%0d", lat_of(k)), o_data[k], exp_q[rd[k]]);
          check($sformatf("latency_L%0d", lat_of(k)), 16'(edge_cnt - exp_edge[rd[k]]),
                16'(lat_of(k) + 2));
          held[k] = exp_q[rd[k]];
          rd[k]++;
        end else begin
          check($sformatf("unexpected_valid_L%0d", lat_of(k)), 16'(o_valid[k]), 16'd0);
        end
      end else begin
        check($sformatf("hold_L%0d", lat_of(k)), o_data[k], held[k]);
        if (rd[k] < exp_q.size() && (edge_cnt - exp_edge[rd[k]]) > lat_of(k) + 2) begin
          check($sformatf("missing_valid_L%0d", lat_of(k)), 16'(o_valid[k]), 16'd1);
          rd[k]++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_payload();
    i_dividend = 9'($urandom_range(0, 511));
    i_divisor  = 9'($urandom_range(0, 511));
    i_function = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      #1;
      i_valid = 1'b0;
      rand_payload();
    end
  endtask

  task automatic send(input int dvd, input int dvs, input int fn);
    @(negedge i_clk);
    #1;
    i_dividend = 9'(dvd);
    i_divisor  = 9'(dvs);
    i_function = 2'(fn);
    i_valid    = 1'b1;
  endtask

  task automatic send_rand();
    @(negedge i_clk);
    #1;
    rand_payload();
    if ($urandom_range(0, 15) == 0) i_divisor = 9'd0;
    i_valid = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      rd[k]   = 0;
      held[k] = 16'd0;
    end
    i_rstn = 1'b0;
    i_valid = 1'b1;
    rand_payload();
    // Reset held with random valid traffic for 100 ns.
    repeat (10) begin
      @(negedge i_clk);
      #1;
      rand_payload();
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    #2;
    i_rstn = 1'b1;

    // Single samples, spaced well apart.
    send(-5, 2, 1);   idle(25);
    send(1, 3, 2);    idle(25);
    send(3, 2, 1);    idle(25);
    send(0, 3, 3);    idle(25);
    send(25, 0, 2);   idle(25);
    send(-42, 0, 1);  idle(25);
    send(-10, 3, 1);  idle(25);
    send(-1, 7, 1);   idle(25);
    send(-256, 1, 1); idle(25);
    send(255, 1, 3);  idle(25);

    // Back-to-back burst.
    send(-5, 2, 1);
    send(1, 3, 2);
    send(0, 3, 3);
    send(25, 0, 1);
    send(3, 2, 1);
    send(0, 0, 0);
    idle(30);

    // Alternating valid.
    for (int i = 0; i < 8; i++) begin
      send_rand();
      idle(1);
    end
    idle(30);

    // Reset with three samples in flight; outputs must clear without a clock edge.
    send_rand();
    send_rand();
    send_rand();
    idle(3);
    @(posedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("async_rst_valid", 16'(o_valid[k]), 16'd0);
      check("async_rst_data", o_data[k], 16'd0);
    end
    idle(3);
    @(negedge i_clk);
    #2;
    i_rstn = 1'b1;
    idle(30);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 7) send_rand();
      else idle(1);
    end
    idle(40);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("drained_L%0d", lat_of(k)), 16'(rd[k]), 16'(exp_q.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout actual=%0t expected=done", $time);
    $fatal(1, "timeout");
  end

endmodule
